// File: rtl/lbr_pkg.sv
// lbr_pkg: shared constants and types for the LBR controller.
//   - Address-region codes (top two bits of the LBR address)
//   - CTRL register bit positions
//   - LBR request encodings
//   - Dump sequencer state type
package lbr_pkg;

  // Region codes carried in the two MSBs of an LBR address.
  localparam logic [1:0] REGION_FROM = 2'b00;
  localparam logic [1:0] REGION_TO   = 2'b01;
  localparam logic [1:0] REGION_TOS  = 2'b10;
  localparam logic [1:0] REGION_CTRL = 2'b11;

  // CTRL register layout; all other bits read as zero.
  localparam int unsigned CTRL_REC_EN_BIT = 0;
  localparam int unsigned CTRL_FROZEN_BIT = 1;

  // lbr_req encodings: {access, write}.
  localparam logic [1:0] LBR_REQ_NONE = 2'b00;
  localparam logic [1:0] LBR_REQ_READ = 2'b10;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StDumpRd  = 2'b01,
    StDumpOut = 2'b10
  } dump_state_e;

endpackage

// File: rtl/lbr_dump_seq.sv
// lbr_dump_seq: dump FSM, beat counter and output register for a full LBR dump.
// Each beat reads one entry (FROM[0..N-1] then TO[0..N-1]) in StDumpRd, then
// presents it in StDumpOut until the consumer accepts it.
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_start               qualified request to begin a dump (only honoured in idle)
//   i_dump_ready          consumer ready
//   i_lbr_rdata           LBR unit combinational read data
//   o_busy                dump in progress
//   o_rd                  high in the read cycle of a beat
//   o_beat                current beat index (doubles as the LBR address)
//   o_dump_valid/_data/_last  dump stream
module lbr_dump_seq
  import lbr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LBR_SIZE   = 16,
  localparam int unsigned BW        = $clog2(2 * LBR_SIZE)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_dump_ready,
  input  logic [DATA_WIDTH-1:0] i_lbr_rdata,
  output logic                  o_busy,
  output logic                  o_rd,
  output logic [BW-1:0]         o_beat,
  output logic                  o_dump_valid,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_last
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(2 * LBR_SIZE - 1);

  dump_state_e           r_state;
  dump_state_e           w_state_next;
  logic [BW-1:0]         r_beat;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic                  w_last_beat;

  assign w_last_beat = (r_beat == LAST_BEAT);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (i_start) w_state_next = StDumpRd;
      StDumpRd:  w_state_next = StDumpOut;
      StDumpOut: if (i_dump_ready) w_state_next = w_last_beat ? StIdle : StDumpRd;
      default:   w_state_next = StIdle;
    endcase
  end

  // Beat counter and captured data.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_beat      <= '0;
      r_dump_data <= '0;
    end else begin
      if (r_state == StDumpRd) begin
        r_dump_data <= i_lbr_rdata;
      end
      if (r_state == StDumpOut && i_dump_ready) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

  // Outputs; forced quiet while reset is held so nothing leaks mid-reset.
  always_comb begin
    o_busy       = (r_state != StIdle);
    o_rd         = ~i_reset & (r_state == StDumpRd);
    o_beat       = r_beat;
    o_dump_valid = ~i_reset & (r_state == StDumpOut);
    o_dump_last  = ~i_reset & (r_state == StDumpOut) & w_last_beat;
    o_dump_data  = i_reset ? '0 : r_dump_data;
  end

endmodule

// File: rtl/lbr_ctrl.sv
// lbr_ctrl: front-end controller for a Last Branch Record unit.
// Arbitrates CSR accesses against branch recording, owns the local CTRL
// register, and streams a full LBR dump through lbr_dump_seq.
// Optional feature macro: LBR_CTRL_FREEZE_EN (record counter that freezes
// recording once LBR_SIZE branches have been captured).
// Ports:
//   i_clock, i_reset                     clock, synchronous active-high reset
//   i_stall, i_next_pc_sel               pipeline stall and next-PC select
//   i_csr_valid/o_csr_ready              CSR request handshake
//   i_csr_write/_addr/_wdata             CSR request payload
//   o_csr_rvalid/_rdata                  one-cycle read response
//   i_dump_start                         dump request pulse
//   o_dump_valid/i_dump_ready/o_dump_data/o_dump_last   dump stream
//   o_lbr_stall/_req/_addr/_wdata        drive the LBR unit
//   i_lbr_rdata                          LBR unit combinational read data
module lbr_ctrl
  import lbr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LBR_SIZE   = 16,
  localparam int unsigned AW        = $clog2(LBR_SIZE) + 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic [1:0]            i_next_pc_sel,
  input  logic                  i_csr_valid,
  output logic                  o_csr_ready,
  input  logic                  i_csr_write,
  input  logic [AW-1:0]         i_csr_addr,
  input  logic [DATA_WIDTH-1:0] i_csr_wdata,
  output logic                  o_csr_rvalid,
  output logic [DATA_WIDTH-1:0] o_csr_rdata,
  input  logic                  i_dump_start,
  output logic                  o_dump_valid,
  input  logic                  i_dump_ready,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_last,
  output logic                  o_lbr_stall,
  output logic [1:0]            o_lbr_req,
  output logic [AW-1:0]         o_lbr_addr,
  output logic [DATA_WIDTH-1:0] o_lbr_wdata,
  input  logic [DATA_WIDTH-1:0] i_lbr_rdata
);

  localparam int unsigned IW = $clog2(LBR_SIZE);
  localparam int unsigned BW = $clog2(2 * LBR_SIZE);

  logic                  r_rec_en;
  logic                  r_dump_pend;
  logic                  r_csr_rvalid;
  logic [DATA_WIDTH-1:0] r_csr_rdata;

  logic                  w_branch_taken;
  logic                  w_branch_rec;
  logic                  w_lbr_stall;
  logic                  w_frozen;
  logic                  w_dump_busy;
  logic                  w_dump_rd;
  logic                  w_dump_go;
  logic [BW-1:0]         w_beat;
  logic                  w_csr_ready;
  logic                  w_accept;
  logic                  w_is_ctrl;
  logic                  w_lbr_acc;
  logic                  w_ctrl_wr;
  logic                  w_csr_rd;
  logic [DATA_WIDTH-1:0] w_ctrl_rdata;
  logic                  w_unused_pc_sel;

  // Only bit1 of next-PC select matters here.
  assign w_unused_pc_sel = i_next_pc_sel[0];

  assign w_branch_taken = ~i_stall & i_next_pc_sel[1];
  assign w_lbr_stall    = i_stall | ~r_rec_en | w_frozen | w_dump_busy;
  // A branch the LBR unit will actually record this cycle; it owns the port.
  assign w_branch_rec   = w_branch_taken & ~w_lbr_stall;

  assign w_csr_ready = ~i_reset & ~w_dump_busy & ~w_branch_rec;
  assign w_accept    = i_csr_valid & w_csr_ready;
  assign w_is_ctrl   = (i_csr_addr[AW-1 -: 2] == REGION_CTRL);
  assign w_lbr_acc   = w_accept & ~w_is_ctrl;
  assign w_ctrl_wr   = w_accept & w_is_ctrl & i_csr_write;
  assign w_csr_rd    = w_accept & ~i_csr_write;

  // CSR wins over a same-cycle dump request; the request waits in r_dump_pend.
  assign w_dump_go = ~i_reset & ~w_dump_busy & (i_dump_start | r_dump_pend) & ~w_accept;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dump_pend <= 1'b0;
    end else if (w_dump_go) begin
      r_dump_pend <= 1'b0;
    end else if (i_dump_start && !w_dump_busy) begin
      r_dump_pend <= 1'b1;
    end
  end

  // CTRL.rec_en
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rec_en <= 1'b1;
    end else if (w_ctrl_wr) begin
      r_rec_en <= i_csr_wdata[CTRL_REC_EN_BIT];
    end
  end

`ifdef LBR_CTRL_FREEZE_EN
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(LBR_SIZE);

  logic [CW-1:0] r_rec_cnt;
  logic          r_frozen;
  logic          w_frz_clr;

  assign w_frz_clr = w_ctrl_wr & i_csr_wdata[CTRL_FROZEN_BIT];

  // Saturating record count; frozen rises on the record that fills the LBR.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rec_cnt <= '0;
      r_frozen  <= 1'b0;
    end else if (w_frz_clr) begin
      r_rec_cnt <= '0;
      r_frozen  <= 1'b0;
    end else if (w_branch_rec) begin
      if (r_rec_cnt != CNT_FULL) begin
        r_rec_cnt <= r_rec_cnt + 1'b1;
      end
      if (r_rec_cnt == CNT_FULL - 1'b1) begin
        r_frozen <= 1'b1;
      end
    end
  end

  assign w_frozen = r_frozen;
`else
  assign w_frozen = 1'b0;
`endif

  always_comb begin
    w_ctrl_rdata                  = '0;
    w_ctrl_rdata[CTRL_REC_EN_BIT] = r_rec_en;
    w_ctrl_rdata[CTRL_FROZEN_BIT] = w_frozen;
  end

  // Read response, registered from the access cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_csr_rvalid <= 1'b0;
      r_csr_rdata  <= '0;
    end else begin
      r_csr_rvalid <= w_csr_rd;
      if (w_csr_rd) begin
        r_csr_rdata <= w_is_ctrl ? w_ctrl_rdata : i_lbr_rdata;
      end
    end
  end

  // LBR unit port: CSR access, else dump read, else idle.
  always_comb begin
    o_lbr_req   = LBR_REQ_NONE;
    o_lbr_addr  = '0;
    o_lbr_wdata = '0;
    if (w_lbr_acc) begin
      o_lbr_req   = {1'b1, i_csr_write};
      o_lbr_addr  = i_csr_addr;
      o_lbr_wdata = i_csr_wdata;
    end else if (w_dump_rd) begin
      o_lbr_req  = LBR_REQ_READ;
      // Beat index maps straight onto {00,idx} then {01,idx}.
      o_lbr_addr = AW'(w_beat);
    end
  end

  assign o_lbr_stall  = w_lbr_stall;
  assign o_csr_ready  = w_csr_ready;
  assign o_csr_rvalid = ~i_reset & r_csr_rvalid;
  assign o_csr_rdata  = i_reset ? '0 : r_csr_rdata;

  lbr_dump_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .LBR_SIZE   (LBR_SIZE)
  ) u_dump_seq (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (w_dump_go),
    .i_dump_ready (i_dump_ready),
    .i_lbr_rdata  (i_lbr_rdata),
    .o_busy       (w_dump_busy),
    .o_rd         (w_dump_rd),
    .o_beat       (w_beat),
    .o_dump_valid (o_dump_valid),
    .o_dump_data  (o_dump_data),
    .o_dump_last  (o_dump_last)
  );

endmodule

// File: tb/tb_lbr_ctrl.sv
// tb_lbr_ctrl: directed self-checking bench for lbr_ctrl (DATA_WIDTH=64, LBR_SIZE=16).
// A small LBR unit model returns a fixed pattern per entry address and a TOS
// value that advances on every branch the controller lets through.
module tb_lbr_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned LS = 16;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [1:0]    pc_sel;
  logic          csr_valid;
  logic          csr_ready;
  logic          csr_write;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata;
  logic          csr_rvalid;
  logic [DW-1:0] csr_rdata;
  logic          dump_start;
  logic          dump_valid;
  logic          dump_ready;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          lbr_stall;
  logic [1:0]    lbr_req;
  logic [AW-1:0] lbr_addr;
  logic [DW-1:0] lbr_wdata;
  logic [DW-1:0] lbr_rdata;
  logic [DW-1:0] m_tos = 64'd0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_entry(input logic [AW-1:0] a);
    return 64'h1000_0000_0000_0000 | (64'(a) * 64'h101);
  endfunction

  assign lbr_rdata = (lbr_addr[AW-1:AW-2] == 2'b10) ? m_tos : model_entry(lbr_addr);

  // TOS advances whenever the LBR unit records a branch.
  always @(posedge clk) begin
    if (!stall && pc_sel[1] && !lbr_stall) m_tos <= m_tos + 64'd1;
  end

  lbr_ctrl #(
    .DATA_WIDTH (DW),
    .LBR_SIZE   (LS)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_stall       (stall),
    .i_next_pc_sel (pc_sel),
    .i_csr_valid   (csr_valid),
    .o_csr_ready   (csr_ready),
    .i_csr_write   (csr_write),
    .i_csr_addr    (csr_addr),
    .i_csr_wdata   (csr_wdata),
    .o_csr_rvalid  (csr_rvalid),
    .o_csr_rdata   (csr_rdata),
    .i_dump_start  (dump_start),
    .o_dump_valid  (dump_valid),
    .i_dump_ready  (dump_ready),
    .o_dump_data   (dump_data),
    .o_dump_last   (dump_last),
    .o_lbr_stall   (lbr_stall),
    .o_lbr_req     (lbr_req),
    .o_lbr_addr    (lbr_addr),
    .o_lbr_wdata   (lbr_wdata),
    .i_lbr_rdata   (lbr_rdata)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_sel = 2'b00;
    csr_valid = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wdata = '0;
    dump_start = 1'b0; dump_ready = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_csr_ready", csr_ready, 0);
    chk("rst_csr_rvalid", csr_rvalid, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_last", dump_last, 0);
    chk("rst_lbr_req", lbr_req, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_csr_rdata", csr_rdata, 0);
    chk("rst_lbr_addr", lbr_addr, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", csr_ready, 1);
    chk("idle_lbr_stall", lbr_stall, 0);

    // CTRL read stays local
    csr_valid = 1'b1; csr_addr = 6'b110000;
    #1;
    chk("ctrl_rd_ready", csr_ready, 1);
    chk("ctrl_rd_local", lbr_req, 2'b00);
    tick(); csr_valid = 1'b0; #1;
    chk("ctrl_rd_rvalid", csr_rvalid, 1);
    chk("ctrl_rd_data", csr_rdata, 64'h1);

    // Read FROM[3]
    tick(); csr_valid = 1'b1; csr_addr = 6'd3; #1;
    chk("from3_ready", csr_ready, 1);
    chk("from3_req", lbr_req, 2'b10);
    chk("from3_addr", lbr_addr, 6'd3);
    tick(); csr_valid = 1'b0; #1;
    chk("from3_rvalid", csr_rvalid, 1);
    chk("from3_rdata", csr_rdata, 64'h1000_0000_0000_0303);
    tick();
    chk("from3_rvalid_drop", csr_rvalid, 0);

    // Stalled branch does not block CSR
    stall = 1'b1; pc_sel = 2'b10; #1;
    chk("stalled_br_ready", csr_ready, 1);
    chk("stalled_br_lbr_stall", lbr_stall, 1);

    // Write coincident with a recorded branch waits one cycle
    tick(); stall = 1'b0; csr_valid = 1'b1; csr_write = 1'b1;
    csr_addr = 6'd5; csr_wdata = 64'hDEAD_BEEF; #1;
    chk("br_wr_ready", csr_ready, 0);
    chk("br_wr_req", lbr_req, 2'b00);
    tick(); pc_sel = 2'b00; #1;
    chk("wr_ready", csr_ready, 1);
    chk("wr_req", lbr_req, 2'b11);
    chk("wr_addr", lbr_addr, 6'd5);
    chk("wr_wdata", lbr_wdata, 64'hDEAD_BEEF);
    tick(); csr_valid = 1'b0; csr_write = 1'b0; #1;
    chk("wr_no_rvalid", csr_rvalid, 0);

    // TOS after the one recorded branch
    csr_valid = 1'b1; csr_addr = 6'b100000;
    tick(); csr_valid = 1'b0; #1;
    chk("tos_rvalid", csr_rvalid, 1);
    chk("tos_one", csr_rdata, 64'd1);

    // Disable recording, then three branches leave TOS alone
    csr_valid = 1'b1; csr_write = 1'b1; csr_addr = 6'b110000; csr_wdata = 64'h0; #1;
    chk("rec_off_same_cycle", lbr_stall, 0);
    tick(); csr_valid = 1'b0; csr_write = 1'b0; #1;
    chk("rec_off_next_cycle", lbr_stall, 1);
    for (int i = 0; i < 3; i++) begin
      pc_sel = 2'b10; #1;
      chk("rec_off_br_ready", csr_ready, 1);
      tick();
    end
    pc_sel = 2'b00;
    csr_valid = 1'b1; csr_addr = 6'b100000;
    tick(); csr_valid = 1'b0; #1;
    chk("tos_unchanged", csr_rdata, 64'd1);
    csr_valid = 1'b1; csr_addr = 6'b110000;
    tick(); csr_valid = 1'b0; #1;
    chk("ctrl_rec_off", csr_rdata, 64'h0);
    csr_valid = 1'b1; csr_write = 1'b1; csr_wdata = 64'h1;
    tick(); csr_valid = 1'b0; csr_write = 1'b0; #1;
    chk("rec_on_again", lbr_stall, 0);

    // Full dump with an initial 5-cycle backpressure
    dump_start = 1'b1; #1;
    chk("dump_start_ready", csr_ready, 1);
    tick(); dump_start = 1'b0; #1;
    chk("dump_rd0_req", lbr_req, 2'b10);
    chk("dump_rd0_addr", lbr_addr, 6'd0);
    chk("dump_rd0_ready", csr_ready, 0);
    chk("dump_rd0_valid", dump_valid, 0);
    chk("dump_rd0_stall", lbr_stall, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("dump_hold_valid", dump_valid, 1);
      chk("dump_hold_data", dump_data, 64'h1000_0000_0000_0000);
      chk("dump_hold_stall", lbr_stall, 1);
      tick();
    end
    for (int b = 0; b < 32; b++) begin
      dump_ready = 1'b1;
      if (b == 5) dump_start = 1'b1;
      #1;
      chk("beat_valid", dump_valid, 1);
      chk("beat_data", dump_data, model_entry(6'(b)));
      chk("beat_last", dump_last, (b == 31));
      chk("beat_stall", lbr_stall, 1);
      tick(); dump_ready = 1'b0; dump_start = 1'b0; #1;
      chk("beat_gap_valid", dump_valid, 0);
      if (b < 31) begin
        chk("beat_rd_addr", lbr_addr, 6'(b + 1));
        tick();
      end
    end
    chk("dump_done_ready", csr_ready, 1);
    tick();
    chk("busy_start_ignored", dump_valid, 0);
    chk("busy_start_no_req", lbr_req, 2'b00);

    // Clear rec_en so the reset value can be observed later
    csr_valid = 1'b1; csr_write = 1'b1; csr_addr = 6'b110000; csr_wdata = 64'h0;
    tick(); csr_valid = 1'b0; csr_write = 1'b0;

    // dump_start loses to a same-cycle CSR read and is held pending
    csr_valid = 1'b1; csr_addr = 6'd2; dump_start = 1'b1; #1;
    chk("pend_csr_ready", csr_ready, 1);
    chk("pend_csr_req", lbr_req, 2'b10);
    chk("pend_csr_addr", lbr_addr, 6'd2);
    tick(); csr_valid = 1'b0; dump_start = 1'b0; #1;
    chk("pend_rvalid", csr_rvalid, 1);
    chk("pend_still_idle", csr_ready, 1);
    chk("pend_no_valid", dump_valid, 0);
    tick();
    chk("pend_dump_req", lbr_req, 2'b10);
    chk("pend_dump_addr", lbr_addr, 6'd0);

    // Reset on beat 7 aborts the dump
    dump_ready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      tick(); tick();
    end
    tick();
    chk("beat7_valid", dump_valid, 1);
    chk("beat7_data", dump_data, 64'h1000_0000_0000_0707);
    rst = 1'b1; #1;
    chk("rst_mid_valid", dump_valid, 0);
    tick(); rst = 1'b0; #1;
    chk("post_rst_valid", dump_valid, 0);
    chk("post_rst_idle", csr_ready, 1);
    chk("post_rst_rec_en", lbr_stall, 0);
    tick();
    chk("post_rst_no_beat", dump_valid, 0);
    chk("post_rst_no_req", lbr_req, 2'b00);
    dump_ready = 1'b0;
    csr_valid = 1'b1; csr_addr = 6'b110000;
    tick(); csr_valid = 1'b0; #1;
    chk("post_rst_ctrl", csr_rdata, 64'h1);

`ifdef LBR_CTRL_FREEZE_EN
    // Sixteen recorded branches freeze the LBR
    for (int i = 0; i < 16; i++) begin
      pc_sel = 2'b10; #1;
      chk("frz_recording", lbr_stall, 0);
      tick();
    end
    chk("frz_stall", lbr_stall, 1);
    chk("frz_br_ready", csr_ready, 1);
    pc_sel = 2'b00;
    csr_valid = 1'b1; csr_addr = 6'b110000;
    tick(); csr_valid = 1'b0; #1;
    chk("frz_ctrl", csr_rdata, 64'h3);
    csr_valid = 1'b1; csr_write = 1'b1; csr_wdata = 64'h3;
    tick(); csr_valid = 1'b0; csr_write = 1'b0; #1;
    chk("frz_resume", lbr_stall, 0);
    csr_valid = 1'b1;
    tick(); csr_valid = 1'b0; #1;
    chk("frz_cleared_ctrl", csr_rdata, 64'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lbr_ctrl.md
LBR_CTRL -- requirements
Module: lbr_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of LBR entries and CSR data.
REQ-002 Parameter LBR_SIZE, default 16, power of two, entry count; AW = clog2(LBR_SIZE)+2 is the LBR address width.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  pipeline stall; branch_taken SHALL be defined as ~stall & next_PC_sel[1].
REQ-006 next_PC_sel  in  2  pipeline next-PC select; bit1 marks a taken jump or branch.
REQ-007 csr_valid / csr_ready  in / out  1 / 1  CSR request handshake; the request is accepted when both are high.
REQ-008 csr_write, csr_addr, csr_wdata  in  1, AW, DATA_WIDTH  CSR write flag, LBR address and write data.
REQ-009 csr_rvalid, csr_rdata  out  1, DATA_WIDTH  one-cycle read response.
REQ-010 dump_start  in  1  pulse that requests a full LBR dump.
REQ-011 dump_valid / dump_ready / dump_data / dump_last  out / in / out / out  1/1/DATA_WIDTH/1  dump stream.
REQ-012 lbr_stall, lbr_req, lbr_addr, lbr_wdata  out  1, 2, AW, DATA_WIDTH  drive the LBR unit's stall, lbrReq, RW_address and ALU_result inputs.
REQ-013 lbr_rdata  in  DATA_WIDTH  LBR unit combinational read data.

Function
REQ-014 Address map: {00,idx} selects FROM[idx], {01,idx} selects TO[idx], {10,0..} selects TOS, {11,0..} selects the controller CTRL register, which is local and is not sent to the LBR unit.
REQ-015 CTRL SHALL contain: bit0 rec_en (RW); bit1 frozen (read, write-1-to-clear); all other bits read as 0.
REQ-016 lbr_stall SHALL equal stall | ~rec_en | frozen | dump_busy, so that recording is suppressed under any of those conditions.
REQ-017 Arbitration: in a cycle where branch_taken is high and lbr_stall is low, csr_ready SHALL be 0 and lbr_req SHALL be 2'b00, so that the recorded branch always wins.
REQ-018 Otherwise, in IDLE, csr_ready SHALL be 1.
REQ-019 On an accepted LBR access, lbr_req SHALL be {1,csr_write} for exactly that cycle, with lbr_addr=csr_addr and lbr_wdata=csr_wdata.
REQ-020 Every accepted read, LBR or CTRL, SHALL assert csr_rvalid in the next cycle, with csr_rdata registered from the access cycle.
REQ-021 An accepted write SHALL produce no csr_rvalid.
REQ-022 FSM states SHALL be IDLE, DUMP_RD, DUMP_OUT.
REQ-023 IDLE -> DUMP_RD on dump_start, taken only if no CSR request is being accepted in the same cycle; CSR has priority and dump_start is held pending until taken.
REQ-024 dump_busy SHALL be 1 in DUMP_RD and DUMP_OUT; csr_ready SHALL be 0 in both states.
REQ-025 DUMP_RD: drive lbr_req=2'b10 with lbr_addr = beat index b (b=0..2*LBR_SIZE-1; FROM entries first, then TO entries), capture lbr_rdata into dump_data, then go to DUMP_OUT.
REQ-026 DUMP_OUT: hold dump_valid=1 with dump_data stable until dump_ready; on the handshake, increment b and return to DUMP_RD, or to IDLE after the last beat.
REQ-027 dump_last SHALL be 1 only on beat 2*LBR_SIZE-1; the maximum throughput is one beat per two cycles.
REQ-028 dump_start while dump_busy SHALL be ignored.
REQ-029 A CTRL write clearing rec_en SHALL take effect on lbr_stall in the next cycle.

Reset
REQ-030 Reset SHALL set state=IDLE, rec_en=1, frozen=0, b=0, and the pending dump flag to 0.
REQ-031 During reset, csr_ready, csr_rvalid, dump_valid, dump_last and lbr_req SHALL be 0, and dump_data, csr_rdata and lbr_addr SHALL be 0.
REQ-032 Reset asserted mid-dump SHALL abort the dump with no further beats.

Configuration
REQ-033 With LBR_CTRL_FREEZE_EN defined: a saturating record counter (clog2(LBR_SIZE)+1 bits) SHALL increment on each unstalled branch_taken.
REQ-034 With LBR_CTRL_FREEZE_EN defined: when a record makes the count reach LBR_SIZE, frozen SHALL set in the following cycle.
REQ-035 With LBR_CTRL_FREEZE_EN defined: a write-1 to CTRL.frozen SHALL clear both frozen and the counter.
REQ-036 Without LBR_CTRL_FREEZE_EN: frozen SHALL be constant 0, there SHALL be no counter, and the LBR wraps freely.

Structure
REQ-037 Package lbr_pkg SHALL hold the address-region constants (FROM, TO, TOS, CTRL), the CTRL bit positions and the FSM state typedef.
REQ-038 One sub-module, lbr_dump_seq, SHALL be used: the dump FSM, beat counter and output register.

Verification
REQ-039 CSR read of FROM[3] with no branch: csr_ready=1, lbr_req=2'b10 and lbr_addr={00,3} in the same cycle; csr_rvalid with that entry's value on the next cycle.
REQ-040 CSR write request coincident with branch_taken: csr_ready=0 and lbr_req=00 that cycle; the write is accepted in the first cycle without a branch.
REQ-041 dump_start with dump_ready held low for 5 cycles: dump_data is stable throughout; all 32 beats complete (LBR_SIZE=16); dump_last is asserted on beat 31 only; lbr_stall is 1 throughout the dump.
REQ-042 With LBR_CTRL_FREEZE_EN, 16 taken branches: frozen=1 and further branches are not recorded (lbr_stall=1); a write of CTRL=0x3 resumes recording.
REQ-043 Reset asserted on dump beat 7: the next cycle shows IDLE, dump_valid=0, rec_en=1.
REQ-044 A CTRL write of 0x0 followed by 3 branches leaves the TOS value unchanged.
